redun_mont_seq: RTL and testbench

Sequencer and result normaliser on the far side of `redun_mont`. It accepts a Montgomery-form start value and an iteration count T. It converts the start value to redundant form and launches it into the squarer with a single `i_val` pulse, then counts the T squarings that `redun_mont` feeds back internally. It captures the T-th redundant product and carry-propagates it word-serially back to non-redundant form before handing it out on a valid/ready port. It is the hardware counterpart of the bench's `to_redun` / `from_redun` / iteration loop, and sits between the host-facing VDF control logic and `redun_mont`.

---
 rtl/redun_mont_seq.sv | 174 +++++++++++++++++
 tb/tb_redun_mont_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redun_mont_seq.sv
`default_nettype none
// ============================================================================
// Module      : redun_mont_seq
// Description : Job sequencer around redun_mont. Converts a Montgomery-form
//               start value to redundant digits, launches it, counts the T
//               squarings fed back inside redun_mont, captures the T-th
//               redundant product and carry-propagates it one word per cycle
//               back to non-redundant form for a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module redun_mont_seq #(
  parameter int NUM_WRDS = 64,
  parameter int WRD_BITS = 16,
  parameter int RED_BITS = 1,
  parameter int T_BITS   = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_WRDS*WRD_BITS-1:0]  i_start_dat,
  input  logic [T_BITS-1:0]             i_t,
  input  logic                          i_start_val,
  output logic                          o_start_rdy,
  output logic [NUM_WRDS*(WRD_BITS+RED_BITS)-1:0] o_sq,
  output logic                          o_sq_val,
  input  logic [NUM_WRDS*(WRD_BITS+RED_BITS)-1:0] i_mul,
  input  logic                          i_mul_val,
  output logic [NUM_WRDS*WRD_BITS-1:0]  o_res,
  output logic                          o_ovf,
  output logic                          o_res_val,
  input  logic                          i_res_rdy,
  output logic [T_BITS-1:0]             o_cnt,
  output logic                          o_busy
);

  localparam int c_DW = WRD_BITS + RED_BITS;
  localparam int c_RW = NUM_WRDS * WRD_BITS;
  localparam int c_SW = NUM_WRDS * c_DW;
  localparam int c_KW = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
  localparam logic [c_KW-1:0] c_K_LAST = c_KW'(NUM_WRDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_NORM   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [T_BITS-1:0]     r_t;
  logic [T_BITS-1:0]     r_cnt;
  logic [c_SW-1:0]       r_dig;
  logic [c_KW-1:0]       r_k;
  logic [RED_BITS:0]     r_carry;
  logic [c_RW-1:0]       r_res;
  logic                  r_ovf;
  logic [c_SW-1:0]       r_sq;
  logic                  r_sq_val;
  logic                  r_start_rdy;
  logic                  r_busy;
  logic                  r_res_val;

  logic [c_SW-1:0]       w_sq_conv;
  logic                  w_accept;
  logic                  w_last_mul;
  logic                  w_k_last;
  logic [c_DW:0]         w_acc;
  logic [RED_BITS:0]     w_carry_nxt;

  // Zero-extend each non-redundant word into a redundant digit.
  for (genvar k = 0; k < NUM_WRDS; k++) begin : g_digit
    assign w_sq_conv[k*c_DW +: c_DW] = {{RED_BITS{1'b0}}, i_start_dat[k*WRD_BITS +: WRD_BITS]};
  end

  assign w_accept    = (r_state == S_IDLE) && i_start_val;
  assign w_last_mul  = (r_state == S_RUN) && i_mul_val && (r_cnt == (r_t - T_BITS'(1)));
  assign w_k_last    = (r_k == c_K_LAST);
  // Lowest remaining digit plus the incoming carry; the digit register shifts down each NORM cycle.
  assign w_acc       = {1'b0, r_dig[c_DW-1:0]} + {{(c_DW-RED_BITS){1'b0}}, r_carry};
  assign w_carry_nxt = w_acc[c_DW:WRD_BITS];

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start_val) w_state_nxt = (i_t == '0) ? S_NORM : S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_RUN;
      S_RUN:    if (w_last_mul) w_state_nxt = S_NORM;
      S_NORM:   if (w_k_last) w_state_nxt = S_DONE;
      S_DONE:   if (i_res_rdy) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Iteration target and squaring counter; RUN exits at the target so the count never exceeds it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_t   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_t   <= i_t;
      r_cnt <= '0;
    end else if ((r_state == S_RUN) && i_mul_val) begin
      r_cnt <= r_cnt + T_BITS'(1);
    end
  end

  // Digit capture and word-serial carry propagation into the result register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dig   <= '0;
      r_k     <= '0;
      r_carry <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept && (i_t == '0)) begin
      r_dig   <= w_sq_conv;
      r_k     <= '0;
      r_carry <= '0;
    end else if (w_last_mul) begin
      r_dig   <= i_mul;
      r_k     <= '0;
      r_carry <= '0;
    end else if (r_state == S_NORM) begin
      r_dig   <= r_dig >> c_DW;
      r_k     <= r_k + c_KW'(1);
      r_carry <= w_carry_nxt;
      // Words enter at the top and move down, so word 0 lands at the bottom after the last step.
      r_res   <= {w_acc[WRD_BITS-1:0], r_res[c_RW-1:WRD_BITS]};
      if (w_k_last) begin
        r_ovf <= |w_carry_nxt;
      end
    end
  end

  // Registered handshake and launch outputs, decoded from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sq        <= '0;
      r_sq_val    <= 1'b0;
      r_start_rdy <= 1'b1;
      r_busy      <= 1'b0;
      r_res_val   <= 1'b0;
    end else begin
      r_sq        <= (w_state_nxt == S_LAUNCH) ? w_sq_conv : '0;
      r_sq_val    <= (w_state_nxt == S_LAUNCH);
      r_start_rdy <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_res_val   <= (w_state_nxt == S_DONE);
    end
  end

  assign o_start_rdy = r_start_rdy;
  assign o_sq        = r_sq;
  assign o_sq_val    = r_sq_val;
  assign o_res       = r_res;
  assign o_ovf       = r_ovf;
  assign o_res_val   = r_res_val;
  assign o_cnt       = r_cnt;
  assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_redun_mont_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_redun_mont_seq
// Description : Scoreboard bench for redun_mont_seq with a behavioural
//               squarer standing in for redun_mont.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_redun_mont_seq;

  localparam int N   = 8;
  localparam int W   = 16;
  localparam int RED = 1;
  localparam int TB  = 8;
  localparam int DW  = W + RED;
  localparam int NW  = N * W;
  localparam int SW  = N * DW;
  localparam logic [NW-1:0] P = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF61;

  logic clk = 1'b0;
  logic rst;
  logic [NW-1:0] i_start_dat;
  logic [TB-1:0] i_t;
  logic          i_start_val;
  logic          o_start_rdy;
  logic [SW-1:0] o_sq;
  logic          o_sq_val;
  logic [SW-1:0] i_mul;
  logic          i_mul_val;
  logic [NW-1:0] o_res;
  logic          o_ovf;
  logic          o_res_val;
  logic          i_res_rdy;
  logic [TB-1:0] o_cnt;
  logic          o_busy;

  always #5 clk = ~clk;

  redun_mont_seq #(.NUM_WRDS(N), .WRD_BITS(W), .RED_BITS(RED), .T_BITS(TB)) dut (
    .i_clk(clk), .i_rst(rst), .i_start_dat(i_start_dat), .i_t(i_t),
    .i_start_val(i_start_val), .o_start_rdy(o_start_rdy), .o_sq(o_sq),
    .o_sq_val(o_sq_val), .i_mul(i_mul), .i_mul_val(i_mul_val), .o_res(o_res),
    .o_ovf(o_ovf), .o_res_val(o_res_val), .i_res_rdy(i_res_rdy), .o_cnt(o_cnt),
    .o_busy(o_busy)
  );

  typedef struct {
    logic [NW-1:0] res;
    logic          ovf;
    logic [TB-1:0] cnt;
  } exp_t;

  exp_t          sb_q[$];
  int            lat_q[$];
  logic [SW-1:0] sq_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_results = 0;
  int cur_t = 0;
  int rdy_mode = 2;
  bit force_mode = 1'b0;
  logic [SW-1:0] force_dig;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stand-in arithmetic for one squaring step of the external squarer.
  function automatic logic [NW-1:0] toy_sq(input logic [NW-1:0] x);
    logic [2*NW-1:0] w;
    w = {{NW{1'b0}}, x};
    w = (w * w + 3) % {{NW{1'b0}}, P};
    return w[NW-1:0];
  endfunction

  // Integer value of a redundant digit vector.
  function automatic logic [NW+3:0] from_redun(input logic [SW-1:0] d);
    logic [NW+3:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + ((NW+4)'(d[k*DW +: DW]) << (k*W));
    return s;
  endfunction

  // Plain digit split of a non-redundant value.
  function automatic logic [SW-1:0] to_digits(input logic [NW-1:0] v);
    logic [SW-1:0] d;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'(v[k*W +: W]);
    return d;
  endfunction

  // Same value, with random borrows leaving carries pending in lower digits.
  function automatic logic [SW-1:0] to_redun_rand(input logic [NW-1:0] v);
    logic [DW-1:0] d[N];
    logic [SW-1:0] o;
    for (int k = 0; k < N; k++) d[k] = DW'(v[k*W +: W]);
    for (int k = 1; k < N; k++) begin
      if ($urandom_range(0, 1) == 1 && d[k] != '0) begin
        d[k]   = d[k] - 1'b1;
        d[k-1] = d[k-1] + DW'(1 << W);
      end
    end
    for (int k = 0; k < N; k++) o[k*DW +: DW] = d[k];
    return o;
  endfunction

  // Result-ready driver.
  initial begin
    i_res_rdy = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       i_res_rdy = 1'($urandom_range(0, 1));
        1:       i_res_rdy = 1'b0;
        default: i_res_rdy = 1'b1;
      endcase
    end
  end

  // Behavioural squarer: after a launch it keeps feeding products back forever.
  initial begin : squarer
    logic [NW-1:0] x;
    logic [NW+3:0] tmp;
    bit active;
    bit pending;
    int pcount;
    active = 0; pending = 0; pcount = 0; x = '0;
    i_mul_val = 1'b0;
    i_mul = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0; pending = 0;
        i_mul_val = 1'b0;
      end else if (o_sq_val) begin
        tmp = from_redun(o_sq);
        x = tmp[NW-1:0];
        active = 1; pending = 1; pcount = 0;
        i_mul_val = 1'b0;
      end else if (active && $urandom_range(0, 2) != 0) begin
        x = toy_sq(x);
        pcount++;
        i_mul = force_mode ? force_dig : to_redun_rand(x);
        i_mul_val = 1'b1;
        if (pending && pcount == cur_t) begin
          lat_q.push_back(cyc + 1 + N);
          pending = 0;
        end
      end else begin
        i_mul_val = 1'b0;
        i_mul = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Output monitor: pops the scoreboard when a result appears.
  initial begin : monitor
    bit prev_val;
    bit prev_sq;
    logic [NW-1:0] hold_res;
    logic hold_ovf;
    exp_t e;
    int lat;
    prev_val = 0; prev_sq = 0; hold_res = '0; hold_ovf = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_val = 0; prev_sq = 0;
        continue;
      end
      if (o_sq_val) begin
        check("sq_pulse_width", 256'(prev_sq), 256'(0));
        if (sq_q.size() == 0) check("spurious_launch", 256'(1), 256'(0));
        else check("sq_value", 256'(o_sq), 256'(sq_q.pop_front()));
      end else begin
        check("sq_zero", 256'(o_sq), 256'(0));
      end
      if (o_res_val && !prev_val) begin
        n_results++;
        hold_res = o_res;
        hold_ovf = o_ovf;
        if (sb_q.size() == 0) begin
          check("unexpected_result", 256'(1), 256'(0));
        end else begin
          e = sb_q.pop_front();
          check("res", 256'(o_res), 256'(e.res));
          check("ovf", 256'(o_ovf), 256'(e.ovf));
          check("cnt", 256'(o_cnt), 256'(e.cnt));
        end
        if (lat_q.size() == 0) check("latency_missing", 256'(1), 256'(0));
        else begin
          lat = lat_q.pop_front();
          check("latency_cycle", 256'(cyc), 256'(lat));
        end
      end else if (o_res_val) begin
        check("res_stable", 256'(o_res), 256'(hold_res));
        check("ovf_stable", 256'(o_ovf), 256'(hold_ovf));
      end
      if (o_res_val) check("rdy_low_in_done", 256'(o_start_rdy), 256'(0));
      prev_val = o_res_val;
      prev_sq = o_sq_val;
    end
  end

  // Issue one job at a negedge once the DUT is ready; pushes the expectation.
  task automatic issue(input logic [NW-1:0] start, input int t);
    exp_t e;
    logic [NW-1:0] v;
    logic [NW+3:0] g;
    int i;
    for (i = 0; i < 2000 && !o_start_rdy; i++) @(negedge clk);
    if (!o_start_rdy) begin
      check("start_rdy_timeout", 256'(1), 256'(0));
      return;
    end
    if (force_mode && t > 0) begin
      g = from_redun(force_dig);
      e.res = g[NW-1:0];
      e.ovf = |g[NW+3:NW];
    end else begin
      v = start;
      for (int s = 0; s < t; s++) v = toy_sq(v);
      e.res = v;
      e.ovf = 1'b0;
    end
    e.cnt = TB'(t);
    sb_q.push_back(e);
    if (t == 0) lat_q.push_back(cyc + 1 + N);
    else sq_q.push_back(to_digits(start));
    cur_t = t;
    i_start_dat = start;
    i_t = TB'(t);
    i_start_val = 1'b1;
    @(negedge clk);
    i_start_val = 1'b0;
    i_start_dat = {$urandom, $urandom, $urandom, $urandom};
    i_t = TB'($urandom);
    check("launch_pulse", 256'(o_sq_val), 256'(t != 0));
    check("busy_after_accept", 256'(o_busy), 256'(1));
    check("cnt_cleared", 256'(o_cnt), 256'(0));
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000 && (sb_q.size() != 0 || !o_start_rdy); i++) @(negedge clk);
    if (sb_q.size() != 0 || !o_start_rdy) check("job_timeout", 256'(1), 256'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_rdy"}, 256'(o_start_rdy), 256'(1));
    check({tag, "_sq_val"},    256'(o_sq_val),    256'(0));
    check({tag, "_sq"},        256'(o_sq),        256'(0));
    check({tag, "_res"},       256'(o_res),       256'(0));
    check({tag, "_ovf"},       256'(o_ovf),       256'(0));
    check({tag, "_res_val"},   256'(o_res_val),   256'(0));
    check({tag, "_cnt"},       256'(o_cnt),       256'(0));
    check({tag, "_busy"},      256'(o_busy),      256'(0));
  endtask

  initial begin : stim
    int i;
    void'($urandom(2));
    rst = 1'b1;
    i_start_val = 1'b0;
    i_start_dat = '0;
    i_t = '0;
    force_dig = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    rdy_mode = 2;

    // T=1 with a product whose every digit carries a pending top bit.
    force_mode = 1'b1;
    for (int k = 0; k < N; k++) force_dig[k*DW +: DW] = {1'b1, 16'($urandom)};
    issue(128'h3, 1);
    wait_idle();

    // Full-length ripple: every digit all-ones, digit 0 at its maximum.
    for (int k = 0; k < N; k++) force_dig[k*DW +: DW] = DW'((1 << W) - 1);
    force_dig[DW-1:0] = DW'((1 << DW) - 1);
    issue({$urandom, $urandom, $urandom, $urandom}, 1);
    wait_idle();
    issue({$urandom, $urandom, $urandom, $urandom}, 3);
    wait_idle();
    force_mode = 1'b0;

    // T=0 bypasses the squarer.
    issue(128'hABCD, 0);
    wait_idle();

    // Backpressure with ignored start requests.
    rdy_mode = 1;
    issue({$urandom, $urandom, $urandom, $urandom}, 2);
    for (i = 0; i < 500 && !o_res_val; i++) @(negedge clk);
    check("bp_res_val_seen", 256'(o_res_val), 256'(1));
    for (int c = 0; c < 50; c++) begin
      i_start_val = 1'($urandom_range(0, 1));
      i_t = TB'($urandom_range(0, 3));
      @(negedge clk);
      check("bp_start_rdy", 256'(o_start_rdy), 256'(0));
      check("bp_res_val", 256'(o_res_val), 256'(1));
    end
    i_start_val = 1'b0;
    rdy_mode = 2;
    wait_idle();

    // Reset in RUN at count 3 of 7, then a clean T=7 job.
    rdy_mode = 0;
    issue({$urandom, $urandom, $urandom, $urandom}, 7);
    for (i = 0; i < 200 && o_cnt != TB'(3); i++) @(negedge clk);
    check("cnt_reached_3", 256'(o_cnt), 256'(3));
    #2 rst = 1'b1;
    #1 check_reset_outputs("abort");
    sb_q.delete();
    lat_q.delete();
    sq_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue({$urandom, $urandom, $urandom, $urandom}, 7);
    wait_idle();

    // Back-to-back jobs with ready held high.
    rdy_mode = 2;
    for (int j = 0; j < 6; j++) issue({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 9));
    wait_idle();

    // Random ready.
    rdy_mode = 0;
    for (int j = 0; j < 8; j++) issue({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 9));
    wait_idle();
    repeat (4) @(negedge clk);

    check("sb_drained", 256'(sb_q.size()), 256'(0));
    check("lat_drained", 256'(lat_q.size()), 256'(0));
    check("sq_drained", 256'(sq_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
